// File: rtl/mundo_pkg.sv
// ============================================================================
// Module      : mundo_pkg
// Description : Shared state encoding and 7-segment glyphs for the match display.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mundo_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      QUALIFY  = 2'd1,
      SHOW     = 2'd2,
      WAIT_REL = 2'd3
   } state_t;

   // Active-low glyphs, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_P     = 7'h0C;

   function automatic logic [6:0] dec_to_seg(input logic [3:0] i_dig);
      logic [6:0] w_pat;
      case (i_dig)
         4'd0:    w_pat = 7'h40;
         4'd1:    w_pat = 7'h79;
         4'd2:    w_pat = 7'h24;
         4'd3:    w_pat = 7'h30;
         4'd4:    w_pat = 7'h19;
         4'd5:    w_pat = 7'h12;
         4'd6:    w_pat = 7'h02;
         4'd7:    w_pat = 7'h78;
         4'd8:    w_pat = 7'h00;
         4'd9:    w_pat = 7'h10;
         default: w_pat = SEG_BLANK;
      endcase
      return w_pat;
   endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_scan4.sv
// ============================================================================
// Module      : seg7_scan4
// Description : 4-digit multiplexed active-low 7-segment scanner, registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg7_scan4 #(
   parameter int SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] i_dig0,
   input  logic [6:0] i_dig1,
   input  logic [6:0] i_dig2,
   input  logic [6:0] i_dig3,
   output logic [3:0] o_an,
   output logic [6:0] o_seg
);
   import mundo_pkg::*;

   localparam int              c_CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SCAN_DIV - 1);

   logic [c_CNT_W-1:0] r_scan_cnt;
   logic [1:0]         r_dig_sel;
   logic [3:0]         r_an;
   logic [6:0]         r_seg;
   logic [6:0]         w_dig_pat;

   always_comb begin
      w_dig_pat = SEG_BLANK;
      case (r_dig_sel)
         2'd0:    w_dig_pat = i_dig0;
         2'd1:    w_dig_pat = i_dig1;
         2'd2:    w_dig_pat = i_dig2;
         default: w_dig_pat = i_dig3;
      endcase
   end

   // an/seg follow the digit select one cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan_cnt <= '0;
         r_dig_sel  <= 2'd0;
         r_an       <= 4'b1110;
         r_seg      <= SEG_BLANK;
      end else begin
         if (r_scan_cnt == c_CNT_LAST) begin
            r_scan_cnt <= '0;
            r_dig_sel  <= r_dig_sel + 2'd1;
         end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
         end
         r_an  <= ~(4'b0001 << r_dig_sel);
         r_seg <= w_dig_pat;
      end
   end

   assign o_an  = r_an;
   assign o_seg = r_seg;

endmodule

`default_nettype wire

// File: rtl/mundo_match_display.sv
// ============================================================================
// Module      : mundo_match_display
// Description : Synchronizes/qualifies per-world Set lines, latches the winner, shows "P-n".
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mundo_match_display #(
   parameter int N_WORLDS      = 8,
   parameter int STABLE_CYCLES = 4,
   parameter int HOLD_CYCLES   = 50000000,
   parameter int SCAN_DIV      = 50000,
   localparam int IW           = $clog2(N_WORLDS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_WORLDS-1:0] i_set_in,
   input  logic                i_ack,
   output logic                o_world_valid,
   output logic [IW-1:0]       o_world_idx,
   output logic                o_busy,
   output logic [3:0]          o_an,
   output logic [6:0]          o_seg
);
   import mundo_pkg::*;

   localparam int              c_STAB_W    = $clog2(STABLE_CYCLES);
   localparam int              c_HOLD_W    = $clog2(HOLD_CYCLES);
   localparam logic [c_STAB_W-1:0] c_STAB_LAST = c_STAB_W'(STABLE_CYCLES - 1);
   localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYCLES - 1);

   logic [N_WORLDS-1:0] r_sync1;
   logic [N_WORLDS-1:0] r_sync2;
   state_t              r_state;
   state_t              w_next_state;
   logic [IW-1:0]       r_cand;
   logic [IW-1:0]       r_world_idx;
   logic [c_STAB_W-1:0] r_stab_cnt;
   logic [c_HOLD_W-1:0] r_hold_cnt;
   logic [IW-1:0]       w_low_idx;
   logic                w_any;
   logic                w_cand_hi;
   logic [6:0]          w_dig0;
   logic [6:0]          w_dig1;
   logic [6:0]          w_dig2;
   logic [6:0]          w_dig3;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= i_set_in;
         r_sync2 <= r_sync1;
      end
   end

   // Descending scan so the lowest asserted index wins
   always_comb begin
      w_low_idx = '0;
      for (int i = N_WORLDS - 1; i >= 0; i--) begin
         if (r_sync2[i]) w_low_idx = IW'(i);
      end
   end

   assign w_any     = |r_sync2;
   assign w_cand_hi = r_sync2[r_cand];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:     if (w_any) w_next_state = QUALIFY;
         QUALIFY: begin
            if (!w_cand_hi)                     w_next_state = IDLE;
            else if (r_stab_cnt == c_STAB_LAST) w_next_state = SHOW;
         end
         SHOW:     if (i_ack || (r_hold_cnt == c_HOLD_LAST)) w_next_state = WAIT_REL;
         WAIT_REL: if (!w_any) w_next_state = IDLE;
         default:  w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cand      <= '0;
         r_world_idx <= '0;
         r_stab_cnt  <= '0;
         r_hold_cnt  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_cand     <= w_low_idx;
                  r_stab_cnt <= c_STAB_W'(1);
               end
            end
            QUALIFY: begin
               if (w_cand_hi) begin
                  if (r_stab_cnt == c_STAB_LAST) begin
                     r_world_idx <= r_cand;
                     r_hold_cnt  <= '0;
                  end else begin
                     r_stab_cnt <= r_stab_cnt + 1'b1;
                  end
               end
            end
            SHOW:    r_hold_cnt <= r_hold_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      o_world_valid = (r_state == SHOW);
      o_busy        = (r_state != IDLE);
      w_dig3        = SEG_DASH;
      w_dig2        = SEG_DASH;
      w_dig1        = SEG_DASH;
      w_dig0        = SEG_DASH;
      if (r_state == SHOW) begin
         w_dig3 = SEG_P;
         w_dig1 = SEG_BLANK;
         w_dig0 = dec_to_seg(4'(r_world_idx) + 4'd1);
      end
   end

   assign o_world_idx = r_world_idx;

   seg7_scan4 #(
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_dig0 (w_dig0),
      .i_dig1 (w_dig1),
      .i_dig2 (w_dig2),
      .i_dig3 (w_dig3),
      .o_an   (o_an),
      .o_seg  (o_seg)
   );

endmodule

`default_nettype wire
